// File: rtl/qmac_pipe.sv
// qmac_pipe: two-stage sign-magnitude fixed-point MUL/ADD/MAC/ACC unit with saturation and overflow flags
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : operand beat handshake (op, a, b, c)
//   clr                    : synchronous clear of acc and ovf_sticky
//   out_valid/out_ready    : result handshake (result, ovf)
//   ovf_sticky, acc        : sticky overflow flag, accumulator value
module qmac_pipe #(
   parameter int N   = 16,
   parameter int Q   = 15,
   parameter int SAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] c,
   input  logic         clr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic         ovf,
   output logic         ovf_sticky,
   output logic [N-1:0] acc
);
   localparam int M = N - 1;
   localparam logic [M-1:0] MAX = '1;
   localparam logic [1:0] OP_MUL = 2'b00, OP_ADD = 2'b01, OP_MAC = 2'b10, OP_ACC = 2'b11;
   logic           r1_valid, r1_psign, r_out_valid, r_ovf, r_sticky;
   logic [1:0]     r1_op;
   logic [2*M-1:0] r1_prod;
   logic [N-1:0]   r1_a, r1_b, r1_c, r_result, r_acc;
   logic           w_stall, w_load, w_povf, w_same, w_xge, w_is_mul, w_sign, w_ovf;
   logic [2*M-1:0] w_p;
   logic [M-1:0]   w_pmag, w_amag, w_mag;
   logic [M:0]     w_sum;
   logic [N-1:0]   w_x, w_y, w_acc_prev, w_res;
   assign w_stall    = r_out_valid & ~out_ready;
   assign w_load     = r1_valid & ~w_stall;
   assign in_ready   = ~w_stall;
   assign out_valid  = r_out_valid;
   assign result     = r_result;
   assign ovf        = r_ovf;
   assign ovf_sticky = r_sticky;
   assign acc        = r_acc;
   always_comb begin
      w_p        = r1_prod >> Q;
      w_povf     = |w_p[2*M-1:M];
      w_pmag     = (w_povf && SAT != 0) ? MAX : w_p[M-1:0];
      // clr in the completing cycle makes an ACC beat start from zero
      w_acc_prev = clr ? '0 : r_acc;
      w_x        = (r1_op == OP_ADD) ? r1_a : {r1_psign, w_pmag};
      w_y        = (r1_op == OP_ADD) ? r1_b : (r1_op == OP_MAC) ? r1_c : w_acc_prev;
      w_sum      = {1'b0, w_x[M-1:0]} + {1'b0, w_y[M-1:0]};
      w_same     = w_x[M] == w_y[M];
      w_xge      = w_x[M-1:0] >= w_y[M-1:0];
      w_amag     = w_same ? ((w_sum[M] && SAT != 0) ? MAX : w_sum[M-1:0])
                          : (w_xge ? w_x[M-1:0] - w_y[M-1:0] : w_y[M-1:0] - w_x[M-1:0]);
      w_is_mul   = r1_op == OP_MUL;
      w_mag      = w_is_mul ? w_pmag : w_amag;
      w_sign     = w_is_mul ? r1_psign : (w_same || w_xge) ? w_x[M] : w_y[M];
      // zero magnitude always leaves as +0
      w_res      = {w_sign & |w_mag, w_mag};
      w_ovf      = (w_povf & (r1_op != OP_ADD)) | (~w_is_mul & w_same & w_sum[M]);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_valid    <= 1'b0;
         r1_op       <= '0;
         r1_psign    <= 1'b0;
         r1_prod     <= '0;
         r1_a        <= '0;
         r1_b        <= '0;
         r1_c        <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_ovf       <= 1'b0;
         r_sticky    <= 1'b0;
         r_acc       <= '0;
      end else begin
         if (!w_stall) begin
            r1_valid    <= in_valid;
            r1_op       <= op;
            r1_psign    <= a[M] ^ b[M];
            r1_prod     <= {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
            r1_a        <= a;
            r1_b        <= b;
            r1_c        <= c;
            r_out_valid <= r1_valid;
         end
         if (w_load) begin
            r_result <= w_res;
            r_ovf    <= w_ovf;
         end
         if (w_load && r1_op == OP_ACC) r_acc <= w_res;
         else if (clr) r_acc <= '0;
         r_sticky <= (r_sticky & ~clr) | (w_load & w_ovf);
      end
   end
endmodule

// File: tb/tb_qmac_pipe.sv
// tb_qmac_pipe: directed self-checking bench for qmac_pipe (SAT=1 main instance, SAT=0 wrap instance)
module tb_qmac_pipe;
   localparam logic [1:0] MUL = 2'b00, ADD = 2'b01, MAC = 2'b10, ACC = 2'b11;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clr = 1'b0, out_ready = 1'b1;
   logic [1:0]  op = '0;
   logic [15:0] a = '0, b = '0, c = '0;
   logic        in_ready, out_valid, ovf, ovf_sticky;
   logic [15:0] result, acc;
   logic        w_in_ready, w_out_valid, w_ovf, w_sticky;
   logic [15:0] w_result, w_acc;
   logic [16:0] exp_q[$];
   logic [16:0] w_seen[$];
   int          n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;
   qmac_pipe #(.N(16), .Q(15), .SAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .c(c), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .ovf(ovf), .ovf_sticky(ovf_sticky), .acc(acc));
   qmac_pipe #(.N(16), .Q(15), .SAT(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .op(op),
      .a(a), .b(b), .c(c), .clr(clr), .out_valid(w_out_valid), .out_ready(out_ready),
      .result(w_result), .ovf(w_ovf), .ovf_sticky(w_sticky), .acc(w_acc));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("unexpected_out", {15'd0, ovf, result}, 32'h1_ffff);
         else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            chk("result", {16'd0, result}, {16'd0, e[15:0]});
            chk("ovf", {31'd0, ovf}, {31'd0, e[16]});
         end
      end
      if (rst_n && w_out_valid && out_ready) w_seen.push_back({w_ovf, w_result});
   end
   task automatic beat(input logic [1:0] o, input logic [15:0] ia, ib, ic, input logic [16:0] e);
      int t = 0;
      in_valid = 1'b1; op = o; a = ia; b = ib; c = ic;
      exp_q.push_back(e);
      @(negedge clk);
      while (!in_ready && t < 50) begin t++; @(negedge clk); end
      if (t >= 50) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask
   task automatic drain;
      int t = 0;
      while (exp_q.size() != 0 && t < 40) begin @(posedge clk); t++; end
      chk("drain", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask
   task automatic pulse_clr;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: timeout");
      $fatal(1);
   end
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_sticky", ovf_sticky, 0);
      chk("rst_acc", acc, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      // latency: accepted at next edge, visible after the one after
      in_valid = 1'b1; op = MUL; a = 16'h4000; b = 16'h4000;
      exp_q.push_back({1'b0, 16'h2000});
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); chk("lat_cycle1", out_valid, 0);
      @(negedge clk); chk("lat_cycle2", out_valid, 1);
      @(posedge clk); #1;
      beat(MUL, 16'h4000, 16'hC000, 0, {1'b0, 16'hA000});
      drain();
      beat(ADD, 16'h6000, 16'h6000, 0, {1'b1, 16'h7FFF});
      beat(ADD, 16'h4000, 16'hC000, 0, {1'b0, 16'h0000});
      beat(ADD, 16'h8000, 16'h0000, 0, {1'b0, 16'h0000});
      drain();
      chk("add_sticky", ovf_sticky, 1);
      pulse_clr();
      @(negedge clk);
      chk("clr_sticky", ovf_sticky, 0);
      chk("clr_acc", acc, 0);
      @(posedge clk); #1;
      w_seen.delete();
      beat(ACC, 16'h4000, 16'h4000, 0, {1'b0, 16'h2000});
      beat(ACC, 16'h4000, 16'h4000, 0, {1'b0, 16'h4000});
      beat(ACC, 16'h4000, 16'h4000, 0, {1'b0, 16'h6000});
      beat(ACC, 16'h4000, 16'h4000, 0, {1'b1, 16'h7FFF});
      drain();
      chk("acc_final", acc, 16'h7FFF);
      chk("acc_sticky", ovf_sticky, 1);
      chk("wrap_count", w_seen.size(), 4);
      if (w_seen.size() == 4) begin
         chk("wrap_first", w_seen[0], {1'b0, 16'h2000});
         chk("wrap_fourth", w_seen[3], {1'b1, 16'h0000});
      end
      chk("wrap_acc", w_acc, 0);
      fork
         begin
            beat(MUL, 16'h4000, 16'h4000, 0, {1'b0, 16'h2000});
            beat(MUL, 16'h4000, 16'h2000, 0, {1'b0, 16'h1000});
            beat(MUL, 16'h4000, 16'h1000, 0, {1'b0, 16'h0800});
            beat(MUL, 16'h4000, 16'h0800, 0, {1'b0, 16'h0400});
            beat(MUL, 16'h4000, 16'hC000, 0, {1'b0, 16'hA000});
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("bp_in_ready", in_ready, 0);
               chk("bp_out_valid", out_valid, 1);
               chk("bp_result_hold", result, 16'h2000);
               @(posedge clk);
            end
            #1 out_ready = 1'b1;
         end
      join
      drain();
      pulse_clr();
      beat(ACC, 16'h6000, 16'h4000, 0, {1'b0, 16'h3000});
      beat(ADD, 16'h6000, 16'h6000, 0, {1'b1, 16'h7FFF});
      drain();
      chk("pre_coll_acc", acc, 16'h3000);
      chk("pre_coll_sticky", ovf_sticky, 1);
      // clr lands exactly on the edge where the ACC beat completes
      in_valid = 1'b1; op = ACC; a = 16'h4000; b = 16'h4000;
      exp_q.push_back({1'b0, 16'h2000});
      @(posedge clk); #1;
      in_valid = 1'b0;
      pulse_clr();
      @(negedge clk);
      chk("coll_acc", acc, 16'h2000);
      chk("coll_sticky", ovf_sticky, 0);
      @(posedge clk); #1;
      beat(MAC, 16'h4000, 16'h4000, 16'hA000, {1'b0, 16'h0000});
      beat(ADD, 16'h6000, 16'h6000, 0, {1'b1, 16'h7FFF});
      drain();
      out_ready = 1'b0;
      in_valid = 1'b1; op = MUL; a = 16'h4000; b = 16'h4000;
      @(posedge clk); #1;
      a = 16'h2000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_acc", acc, 0);
      chk("mid_rst_sticky", ovf_sticky, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
      chk("post_rst_queue", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/qmac_pipe.md
Name: qmac_pipe

Overview:
- Pipelined sign-magnitude fixed-point multiply/add/accumulate unit. Parametrised successor to the combinational qmult/qadd pair.
- Adds valid/ready handshaking, a persistent accumulator, overflow saturation, and per-result and sticky overflow flags.
- Sits between register-file reads and the writeback path of the receiver datapath.

Parameters:
- N, 16, total word width; bit N-1 is sign, bits N-2:0 are magnitude.
- Q, 15, fractional bits of the magnitude; legal range 0..N-1.
- SAT, 1, 1 = saturate on overflow; 0 = keep low N-1 magnitude bits (wrap).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts beat this cycle.
- op  in  2  00 MUL a*b; 01 ADD a+b; 10 MAC a*b+c; 11 ACC acc+a*b.
- a  in  N  operand A, sign-magnitude Q-format.
- b  in  N  operand B.
- c  in  N  addend for MAC.
- clr  in  1  synchronous accumulator and sticky-flag clear.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  N  sign-magnitude result.
- ovf  out  1  overflow occurred in this result; qualified by out_valid.
- ovf_sticky  out  1  OR of every ovf since reset/clr.
- acc  out  N  current accumulator value.

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-low.
- Reset values: out_valid=0, result=0, ovf=0, ovf_sticky=0, acc=0, and all internal stage valids=0.
  - Reset mid-operation discards every in-flight beat. No output appears for those beats after rst_n deasserts.
- Pipeline: two register stages.
  - S1: sign = a[N-1]^b[N-1]; magnitude product of a[N-2:0] and b[N-2:0], 2(N-1) bits; register op, c and the product.
  - S2: scale, add, saturate; load the output register.
  - Latency is 2 cycles from input handshake (in_valid & in_ready) to out_valid when no backpressure. Throughput is one beat per cycle.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, all stages hold; result, ovf and out_valid remain stable.
  - in_valid with in_ready=0 is not consumed. The source must hold the beat.
  - Bubbles propagate as invalid; out_valid drops after a handshake if no valid beat follows.
- Multiply scaling:
  - p = product >> Q, truncated toward zero.
  - If p > 2^(N-1)-1, the multiply overflows: magnitude = 2^(N-1)-1 if SAT, else p[N-2:0]; ovf=1.
- Add (ADD, MAC second operand c, ACC second operand acc) uses sign-magnitude rules:
  - Equal signs: add magnitudes, keep the sign. A carry out of N-1 bits is overflow, handled as above.
  - Differing signs: subtract the smaller magnitude from the larger; the sign is that of the larger.
- Zero normalisation: any zero magnitude gets sign 0. 0x8000-style negative zero is never output; a negative-zero input is treated as +0.
- MUL passes the scaled product. ADD performs no multiply; S1 forwards a and b.
- MAC: product overflow and add overflow are ORed into ovf. The saturated product feeds the add.
- ACC:
  - acc <= result in the cycle the beat loads the S2 output register (not stalled).
  - Back-to-back ACC beats see the updated acc with no hazard.
- clr:
  - clr=1 sets acc to 0 and ovf_sticky to 0 in that cycle.
  - If an ACC beat completes in the same cycle, it uses 0 as the prior acc; acc <= product and ovf_sticky <= that beat's ovf.
  - clr does not affect beats in flight for other ops.
- ovf_sticky sets on any completed beat with ovf=1.

Test Plan:
- MUL, N=16, Q=15: a=0x4000, b=0x4000 -> result 0x2000, ovf=0, 2 cycles after accept. a=0x4000, b=0xC000 -> 0xA000.
- ADD: 0x6000+0x6000 -> 0x7FFF, ovf=1, ovf_sticky=1. 0x4000+0xC000 -> 0x0000 (not 0x8000). 0x8000+0x0000 -> 0x0000.
- ACC: pulse clr, then four back-to-back ACC beats with a=b=0x4000 -> results 0x2000, 0x4000, 0x6000, 0x7FFF; ovf only on the 4th; acc=0x7FFF. With SAT=0 the 4th beat gives 0x0000, ovf=1.
- Backpressure: in_valid held with 5 distinct MUL beats, out_ready low for cycles 3-5 -> in_ready low while stalled, result stable, all 5 results emerge in order with no loss or duplication.
- MAC plus clr collision: acc=0x3000, clr asserted with an ACC beat a=b=0x4000 completing -> result 0x2000, acc=0x2000, ovf_sticky=0. Then MAC a=0x4000, b=0x4000, c=0xA000 -> 0x8000 normalised to 0x0000.
- Reset mid-flight: rst_n low for 1 cycle with two beats in S1/S2 -> out_valid=0, acc=0, ovf_sticky=0 immediately (asynchronous); no stale results after release.
